// File: rtl/icache_fill_ctrl.sv
// rtl/icache_fill_ctrl.sv - direct-mapped read-only instruction cache with 4-word line fill
module icache_fill_ctrl #(
  parameter int INDEX_BITS = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] Addr,
  input  logic        Rd,
  output logic [15:0] DataOut,
  output logic        Done,
  output logic        CacheHit,
  output logic        Stall,
  output logic        valid,
  output logic        err,
  output logic        mem_rd,
  output logic [15:0] mem_addr,
  input  logic [15:0] mem_rdata,
  input  logic        mem_rvalid
);

  localparam int TAG_BITS = 16 - INDEX_BITS - 3;
  localparam int LINES    = 1 << INDEX_BITS;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t              state_q;
  logic [1:0]          k_q;
  logic [15:1]         miss_addr_q;
  logic [LINES-1:0]    line_valid_q;
  logic [TAG_BITS-1:0] tag_q  [LINES];
  logic [15:0]         data_q [LINES*4];

  logic [INDEX_BITS-1:0] addr_idx;
  logic [INDEX_BITS-1:0] miss_idx;
  logic [TAG_BITS-1:0]   addr_tag;
  logic                  req_ok;
  logic                  hit;
  logic                  miss;

  assign addr_idx = Addr[INDEX_BITS+2:3];
  assign addr_tag = Addr[15:INDEX_BITS+3];
  assign miss_idx = miss_addr_q[INDEX_BITS+2:3];

  // Lookup only happens in IDLE; misaligned requests never touch the array
  assign req_ok = (state_q == S_IDLE) && Rd && !Addr[0];
  assign hit    = req_ok && line_valid_q[addr_idx] && (tag_q[addr_idx] == addr_tag);
  assign miss   = req_ok && !hit;

  // Fill sequencer: words always fetched 0..3, line marked valid only after the last one
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      k_q          <= 2'd0;
      miss_addr_q  <= '0;
      line_valid_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (miss) begin
            miss_addr_q            <= Addr[15:1];
            line_valid_q[addr_idx] <= 1'b0;
            k_q                    <= 2'd0;
            state_q                <= S_REQ;
          end
        end
        S_REQ: state_q <= S_WAIT;
        S_WAIT: begin
          if (mem_rvalid) begin
            if (k_q == 2'd3) begin
              line_valid_q[miss_idx] <= 1'b1;
              state_q                <= S_RESP;
            end else begin
              k_q     <= k_q + 2'd1;
              state_q <= S_REQ;
            end
          end
        end
        S_RESP: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Tag and data arrays carry no reset; the valid bits alone decide whether they are trusted
  always_ff @(posedge clk) begin
    if (!rst && miss) begin
      tag_q[addr_idx] <= addr_tag;
    end
    if (!rst && (state_q == S_WAIT) && mem_rvalid) begin
      data_q[{miss_idx, k_q}] <= mem_rdata;
    end
  end

  // Output decode: hit path is combinational so a hit costs zero cycles
  always_comb begin
    DataOut  = 16'h0000;
    Done     = 1'b0;
    CacheHit = 1'b0;
    Stall    = 1'b0;
    valid    = 1'b0;
    err      = 1'b0;
    mem_rd   = 1'b0;
    mem_addr = 16'h0000;
    case (state_q)
      S_IDLE: begin
        if (Rd) begin
          if (Addr[0]) begin
            err = 1'b1;
          end else if (hit) begin
            DataOut  = data_q[{addr_idx, Addr[2:1]}];
            Done     = 1'b1;
            valid    = 1'b1;
            CacheHit = 1'b1;
          end else begin
            Stall = 1'b1;
          end
        end
      end
      S_REQ: begin
        Stall    = 1'b1;
        mem_rd   = 1'b1;
        mem_addr = {miss_addr_q[15:3], k_q, 1'b0};
      end
      S_WAIT: begin
        Stall = 1'b1;
      end
      S_RESP: begin
        DataOut = data_q[{miss_idx, miss_addr_q[2:1]}];
        Done    = 1'b1;
        valid   = 1'b1;
        Stall   = 1'b1;
      end
      default: begin
        Stall = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_icache_fill_ctrl.sv
// tb/tb_icache_fill_ctrl.sv - scoreboard bench for icache_fill_ctrl
module tb_icache_fill_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] Addr;
  logic        Rd;
  logic [15:0] DataOut;
  logic        Done;
  logic        CacheHit;
  logic        Stall;
  logic        valid;
  logic        err;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic [15:0] mem_rdata;
  logic        mem_rvalid;

  icache_fill_ctrl #(.INDEX_BITS(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .Addr      (Addr),
    .Rd        (Rd),
    .DataOut   (DataOut),
    .Done      (Done),
    .CacheHit  (CacheHit),
    .Stall     (Stall),
    .valid     (valid),
    .err       (err),
    .mem_rd    (mem_rd),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .mem_rvalid(mem_rvalid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    logic        hit;
    int          due;
  } resp_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          lat = 2;
  resp_t       resp_q[$];
  logic [15:0] madr_q[$];
  resp_t       mon_r;
  logic        mv [32];
  logic [7:0]  mt [32];
  int          mem_rd_cnt = 0;
  logic        req_seen = 1'b0;
  logic [15:0] req_addr = 16'h0000;
  int          pend = 0;
  logic [15:0] pend_addr = 16'h0000;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return (a * 16'd7) ^ 16'hC3A5;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Backing memory: answers each request exactly lat cycles later
  initial begin
    mem_rvalid = 1'b0;
    mem_rdata  = 16'h0000;
    forever begin
      @(posedge clk);
      #1;
      mem_rvalid = 1'b0;
      if (req_seen) begin
        pend      = lat;
        pend_addr = req_addr;
        req_seen  = 1'b0;
      end
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = mem_word(pend_addr);
        end
      end
    end
  end

  // Monitor: pops expected memory addresses and responses as the DUT produces them
  initial begin
    forever begin
      @(negedge clk);
      if (mem_rd) begin
        mem_rd_cnt++;
        req_seen = 1'b1;
        req_addr = mem_addr;
        if (madr_q.size() == 0) check("mem_rd_unexpected", 32'(mem_rd), 32'd0);
        else check("mem_addr", 32'(mem_addr), 32'(madr_q.pop_front()));
        check("stall_on_req", 32'(Stall), 32'd1);
      end
      if (Done) begin
        if (resp_q.size() == 0) begin
          check("done_unexpected", 32'(Done), 32'd0);
        end else begin
          mon_r = resp_q.pop_front();
          check("data", 32'(DataOut), 32'(mon_r.data));
          check("cache_hit", 32'(CacheHit), 32'(mon_r.hit));
          check("done_cycle", 32'(cyc), 32'(mon_r.due));
          check("valid_eq_done", 32'(valid), 32'd1);
          check("stall_vs_hit", 32'(Stall), 32'(!mon_r.hit));
        end
      end
    end
  end

  // Reference cache: decides hit/miss and queues the expected memory traffic
  task automatic predict(input logic [15:0] a);
    int         idx;
    logic [7:0] tg;
    resp_t      r;
    idx    = int'(a[7:3]);
    tg     = a[15:8];
    r.hit  = mv[idx] && (mt[idx] == tg);
    r.data = mem_word({a[15:1], 1'b0});
    r.due  = cyc + (r.hit ? 0 : 4 * lat + 5);
    resp_q.push_back(r);
    if (!r.hit) begin
      mv[idx] = 1'b1;
      mt[idx] = tg;
      for (int k = 0; k < 4; k++) madr_q.push_back({a[15:3], 2'(k), 1'b0});
    end
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!Done && n < 200);
    if (!Done) check(tag, 32'(Done), 32'd1);
  endtask

  task automatic access(input logic [15:0] a);
    @(posedge clk);
    #1;
    Addr = a;
    Rd   = 1'b1;
    predict(a);
    wait_done("timeout_access");
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_done"},     32'(Done),     32'd0);
    check({tag, "_hit"},      32'(CacheHit), 32'd0);
    check({tag, "_valid"},    32'(valid),    32'd0);
    check({tag, "_err"},      32'(err),      32'd0);
    check({tag, "_stall"},    32'(Stall),    32'd0);
    check({tag, "_mem_rd"},   32'(mem_rd),   32'd0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_data"},     32'(DataOut),  32'd0);
  endtask

  initial begin
    int base_cnt;
    int n;
    logic [15:0] b;
    foreach (mv[i]) begin
      mv[i] = 1'b0;
      mt[i] = 8'h00;
    end
    rst  = 1'b1;
    Addr = 16'h0000;
    Rd   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // cold miss then same-line hit
    lat = 2;
    access(16'h0004);
    access(16'h0002);

    // conflict on index 0
    access(16'h0000);
    access(16'h0100);
    access(16'h0104);
    access(16'h0000);

    // misaligned and idle
    @(posedge clk);
    #1;
    Addr = 16'h0003;
    Rd   = 1'b1;
    @(negedge clk);
    check("misaligned_err", 32'(err), 32'd1);
    check("misaligned_stall", 32'(Stall), 32'd0);
    check("misaligned_done", 32'(Done), 32'd0);
    check("misaligned_mem_rd", 32'(mem_rd), 32'd0);
    @(posedge clk);
    #1;
    Rd = 1'b0;
    @(negedge clk);
    check_zero("rd_low");

    // redirect during WAIT
    @(posedge clk);
    #1;
    Addr = 16'h0010;
    Rd   = 1'b1;
    predict(16'h0010);
    repeat (2) @(posedge clk);
    #1;
    Addr = 16'h0040;
    wait_done("timeout_redirect");
    @(posedge clk);
    #1;
    predict(16'h0040);
    wait_done("timeout_redirect_new");
    access(16'h0012);

    // reset during WAIT of word 2
    @(posedge clk);
    #1;
    Rd = 1'b0;
    base_cnt = mem_rd_cnt;
    @(posedge clk);
    #1;
    Addr = 16'h0088;
    Rd   = 1'b1;
    predict(16'h0088);
    n = 0;
    while (mem_rd_cnt < base_cnt + 3 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("reach_word2", 32'(mem_rd_cnt), 32'(base_cnt + 3));
    @(posedge clk);
    #1;
    rst = 1'b1;
    Rd  = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    resp_q.delete();
    madr_q.delete();
    foreach (mv[i]) mv[i] = 1'b0;
    @(negedge clk);
    check_zero("mid_fill_reset");
    repeat (4) @(posedge clk);
    access(16'h0088);

    // latency sweep with back-to-back hits
    foreach (mv[i]) n = i;
    for (int s = 0; s < 3; s++) begin
      @(posedge clk);
      #1;
      Rd  = 1'b0;
      lat = (s == 0) ? 1 : ((s == 1) ? 3 : 7);
      b   = 16'h0400 | 16'(lat << 3);
      access(b);
      access(b | 16'h0002);
      access(b | 16'h0004);
      access(b | 16'h0006);
      access(b);
    end

    @(posedge clk);
    #1;
    Rd = 1'b0;
    repeat (3) @(posedge clk);
    check("resp_q_drained", 32'(resp_q.size()), 32'd0);
    check("madr_q_drained", 32'(madr_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/icache_fill_ctrl.md
# icache_fill_ctrl

Read-only, direct-mapped instruction cache with a line-fill state machine. It sits directly upstream of the fetch stage. Fetch presents the PC on `Addr` with `Rd` high. A hit returns the instruction in the same cycle. A miss holds `Stall` high while a 4-word line is fetched, one word at a time, from a single-outstanding-request backing memory. The requested word is then returned with `Done`.

## Interface
Parameters:
- `INDEX_BITS`, default 5. Number of lines is 2^INDEX_BITS. Tag width is `16 - INDEX_BITS - 3`.

Ports:
- `clk`, in, 1: the single clock.
- `rst`, in, 1: synchronous, active-high reset.
- `Addr`, in, 16: byte address. Offset is [2:1], index is [INDEX_BITS+2:3], tag is [15:INDEX_BITS+3].
- `Rd`, in, 1: access request, sampled in IDLE.
- `DataOut`, out, 16: instruction word, meaningful only when `Done=1`.
- `Done`, out, 1: `DataOut` is valid this cycle.
- `CacheHit`, out, 1: `Done` came from a hit.
- `Stall`, out, 1: cache busy. Fetch must hold the PC.
- `valid`, out, 1: equal to `Done`. Fetch uses it to select a NOP otherwise.
- `err`, out, 1: misaligned request (`Addr[0]=1` with `Rd=1` in IDLE).
- `mem_rd`, out, 1: one-cycle read request to backing memory.
- `mem_addr`, out, 16: word-aligned read address.
- `mem_rdata`, in, 16: read data.
- `mem_rvalid`, in, 1: `mem_rdata` valid. It arrives L≥1 cycles after `mem_rd`, with exactly one response per request.

## Operation
Storage:
- Per line: valid bit, tag, 4×16 data words.
- Valid bits are flops cleared by `rst`. Tag and data are not reset.

States: IDLE, REQ, WAIT, RESP.
- IDLE, hit (`Rd`, `Addr[0]=0`, line valid, tags match):
  - Outputs combinational: `DataOut` = stored word, `Done=valid=CacheHit=1`, `Stall=0`.
  - Stay in IDLE.
- IDLE, miss:
  - Latch `Addr` into `miss_addr`.
  - Clear the line's valid bit and write its tag.
  - Set word counter `k=0`.
  - `Stall=1` combinationally this cycle. `Done=0`.
  - Next state: REQ.
- IDLE, misaligned: `err=1`, `Done=0`, `Stall=0`, no memory access. Stay in IDLE.
- IDLE, `Rd=0`: all outputs 0.
- REQ:
  - `mem_rd=1` and `mem_addr = {miss_addr[15:3], k[1:0], 1'b0}`.
  - Next state: WAIT.
- WAIT:
  - Hold until `mem_rvalid`.
  - On `mem_rvalid`, write `mem_rdata` into word k.
  - If k<3: k++ and go to REQ.
  - If k=3: set the valid bit and go to RESP.
- RESP:
  - `DataOut` = word `miss_addr[2:1]`, `Done=valid=1`, `CacheHit=0`, `Stall=1`.
  - Next state: IDLE.
- `Stall=1` in REQ, WAIT and RESP.
- `Addr` and `Rd` are ignored outside IDLE. A fill always completes for `miss_addr`, even if fetch redirects mid-fill. The RESP word is for `miss_addr`, and fetch discards it if it is stale.
- `mem_rvalid` in IDLE, REQ or RESP is ignored.
- Synchronous `rst` at any point, including mid-fill:
  - State goes to IDLE, k=0, and all valid bits are cleared.
  - The partially filled line is never marked valid.
  - An outstanding memory response arriving after reset is ignored.

## Timing
- Reset values: `Done=CacheHit=valid=err=Stall=mem_rd=0`, `mem_addr=0`, `DataOut=0`.
- Hit: 0-cycle latency, and one access can be issued per cycle.
- Miss: detected in cycle 0.
  - Word k: REQ in cycle 1+k(L+1), response in cycle 1+k(L+1)+L.
  - RESP (`Done`) in cycle 4L+5. Examples: L=1 gives 9, L=2 gives 13.
  - IDLE resumes in cycle 4L+6, and the next access is accepted there.
- `Stall` is high from cycle 0 through RESP inclusive. It drops in the first IDLE cycle unless that cycle misses again.
- Word fill order is always 0,1,2,3. There is no critical-word-first.

## Test plan
- Cold miss, `Addr=0x0004`, L=2 → `mem_rd` pulses with `mem_addr` 0x0000, 0x0002, 0x0004, 0x0006. `Done=1`, `CacheHit=0` at cycle 13, with `DataOut` = the 3rd returned word. Then `Addr=0x0002` → same-cycle `Done=CacheHit=1`.
- Conflict: fill 0x0000, then 0x0100 (index 0, different tag) misses and replaces the line. 0x0000 then misses again, and 0x0104 hits.
- `Addr=0x0003`, `Rd=1` → `err=1`, `Stall=0`, `Done=0`, no `mem_rd`. `Rd=0` → all outputs 0.
- Redirect mid-fill: `Addr` changes to 0x0040 during WAIT → fill still targets the original line, and RESP returns the original word. 0x0040 is evaluated in the following IDLE cycle and misses.
- `rst` asserted during WAIT of word 2, with the late `mem_rvalid` ignored → outputs return to reset values. The line stays invalid, so re-requesting the same address misses.
- Latency sweep L=1,3,7 with back-to-back hits after fill → `Done` at cycle 4L+5, and `Stall` never overlaps a hit `Done`.
